// File: rtl/sram_load_pkg.sv
// Shared types and helpers for the layer operand load sequencer.
// The bus width is a power of two, so ceiling division is a shift plus a round-up bit.
package sram_load_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        FIL  = 3'd2,
        IFM  = 3'd3,
        DONE = 3'd4
    } state_e;

    typedef enum logic {
        MODE_FIL = 1'b0,
        MODE_IFM = 1'b1
    } mode_e;

    // Returns ceil(num / 2**lg). Any bit below the shift point rounds the quotient up.
    function automatic logic [31:0] ceil_div_bus(input logic [31:0] num, input int unsigned lg);
        logic [31:0] mask;
        mask = (32'd1 << lg) - 32'd1;
        return (num >> lg) + {31'd0, |(num & mask)};
    endfunction

endpackage

// File: rtl/sram_load_scheduler_chunk_counter.sv
// Nested beat / row / z-slice counters for one load phase.
// Slices are walked by a remaining-channel register, so no divider is needed.
module sram_chunk_counter
    import sram_load_pkg::*;
#(
    parameter int unsigned BUS_SIZE       = 32,
    parameter int unsigned WR_DAT_CYC_NUM = 16,
    parameter int unsigned CFG_W          = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              init_i,
    input  logic                              adv_i,
    input  mode_e                             mode_i,
    input  logic [CFG_W-1:0]                  ch_i,
    input  logic [CFG_W-1:0]                  div_i,
    input  logic [CFG_W-1:0]                  ifm_x_i,
    input  logic [CFG_W-1:0]                  ifm_y_i,
    input  logic [$clog2(WR_DAT_CYC_NUM):0]   fil_beats_i,
    output logic [$clog2(WR_DAT_CYC_NUM)-1:0] dat_o,
    output logic [CFG_W-1:0]                  row_o,
    output logic [CFG_W-1:0]                  slice_o,
    output logic                              phase_last_o
);

    localparam int unsigned LG_BUS = $clog2(BUS_SIZE);
    localparam int unsigned DAT_W  = $clog2(WR_DAT_CYC_NUM);
    localparam int unsigned BEAT_W = DAT_W + 1;

    logic [DAT_W-1:0]   beat_q, beat_d;
    logic [CFG_W-1:0]   row_q, row_d;
    logic [CFG_W-1:0]   slice_q, slice_d;
    logic [CFG_W-1:0]   rem_q, rem_d;

    logic               slice_last, row_last, beat_last;
    logic [CFG_W-1:0]   cz;
    logic [2*CFG_W-1:0] ifm_area;
    logic [31:0]        ifm_beats_w;
    logic [BEAT_W-1:0]  beats_cur;

    always_comb begin
        slice_last  = (rem_q <= div_i);
        cz          = slice_last ? rem_q : div_i;
        // The final slice may carry fewer channels, hence fewer IFM beats per row.
        ifm_area    = {{CFG_W{1'b0}}, ifm_x_i} * {{CFG_W{1'b0}}, cz};
        ifm_beats_w = ceil_div_bus(32'(ifm_area), LG_BUS);
        beats_cur   = (mode_i == MODE_IFM) ? BEAT_W'(ifm_beats_w) : fil_beats_i;
        beat_last   = ({1'b0, beat_q} == (beats_cur - BEAT_W'(1)));
        row_last    = (row_q == (ifm_y_i - CFG_W'(1)));
    end

    always_comb begin
        beat_d  = beat_q;
        row_d   = row_q;
        slice_d = slice_q;
        rem_d   = rem_q;
        if (init_i) begin
            beat_d  = '0;
            row_d   = '0;
            slice_d = '0;
            rem_d   = ch_i;
        end else if (adv_i) begin
            if (!beat_last) begin
                beat_d = beat_q + DAT_W'(1);
            end else begin
                beat_d = '0;
                if ((mode_i == MODE_IFM) && !row_last) begin
                    row_d = row_q + CFG_W'(1);
                end else begin
                    row_d = '0;
                    // Wrapping back to slice 0 re-arms the walk for the next phase.
                    if (slice_last) begin
                        slice_d = '0;
                        rem_d   = ch_i;
                    end else begin
                        slice_d = slice_q + CFG_W'(1);
                        rem_d   = rem_q - div_i;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q  <= '0;
            row_q   <= '0;
            slice_q <= '0;
            rem_q   <= '0;
        end else begin
            beat_q  <= beat_d;
            row_q   <= row_d;
            slice_q <= slice_d;
            rem_q   <= rem_d;
        end
    end

    assign dat_o        = beat_q;
    assign row_o        = row_q;
    assign slice_o      = slice_q;
    assign phase_last_o = beat_last && slice_last && ((mode_i == MODE_FIL) || row_last);

endmodule

// File: rtl/sram_load_scheduler.sv
// Loads one layer's compressed filter chunks, then IFM chunks, from a shared beat stream
// into the filter and IFM SRAM write ports with one cycle of latency.
module sram_load_scheduler
    import sram_load_pkg::*;
#(
    parameter int unsigned BUS_SIZE        = 32,
    parameter int unsigned DAT_SIZE        = 8,
    parameter int unsigned WR_DAT_CYC_NUM  = 16,
    parameter int unsigned SRAM_IFM_NUM    = 64,
    parameter int unsigned SRAM_FILTER_NUM = 16,
    parameter int unsigned CFG_W           = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 load_start_i,
    input  logic [CFG_W-1:0]                     cfg_channel_num_i,
    input  logic [CFG_W-1:0]                     cfg_div_channel_num_i,
    input  logic [CFG_W-1:0]                     cfg_ifm_x_i,
    input  logic [CFG_W-1:0]                     cfg_ifm_y_i,
    input  logic [CFG_W-1:0]                     cfg_fil_x_i,
    input  logic [CFG_W-1:0]                     cfg_fil_y_i,
    input  logic [BUS_SIZE-1:0]                  in_sparsemap_i,
    input  logic [BUS_SIZE*DAT_SIZE-1:0]         in_nonzero_data_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    output logic                                 load_finish_o,
    output logic                                 load_err_o,
    output logic [BUS_SIZE-1:0]                  fil_sram_wr_sparsemap_o,
    output logic [BUS_SIZE*DAT_SIZE-1:0]         fil_sram_wr_nonzero_data_o,
    output logic                                 fil_sram_wr_valid_o,
    output logic [$clog2(WR_DAT_CYC_NUM)-1:0]    fil_sram_wr_dat_count_o,
    output logic [$clog2(SRAM_FILTER_NUM)-1:0]   fil_sram_wr_chunk_count_o,
    output logic [BUS_SIZE-1:0]                  ifm_sram_wr_sparsemap_o,
    output logic [BUS_SIZE*DAT_SIZE-1:0]         ifm_sram_wr_nonzero_data_o,
    output logic                                 ifm_sram_wr_valid_o,
    output logic [$clog2(WR_DAT_CYC_NUM)-1:0]    ifm_sram_wr_dat_count_o,
    output logic [$clog2(SRAM_IFM_NUM)-1:0]      ifm_sram_wr_chunk_count_o
);

    localparam int unsigned LG_BUS = $clog2(BUS_SIZE);
    localparam int unsigned DAT_W  = $clog2(WR_DAT_CYC_NUM);
    localparam int unsigned BEAT_W = DAT_W + 1;
    localparam int unsigned FIL_CW = $clog2(SRAM_FILTER_NUM);
    localparam int unsigned IFM_CW = $clog2(SRAM_IFM_NUM);

    state_e             state_q, state_d;
    logic [CFG_W-1:0]   ch_q, div_q, ifm_x_q, ifm_y_q, fil_x_q, fil_y_q;
    logic               err_q;

    logic [3*CFG_W-1:0] fil_vol;
    logic [2*CFG_W-1:0] ifm_row_vol;
    logic [31:0]        fil_beats_w, ifm_full_w;
    logic               cfg_err;
    logic               accept;
    mode_e              mode;
    logic [DAT_W-1:0]   cnt_dat;
    logic [CFG_W-1:0]   cnt_row, cnt_slice;
    logic               phase_last;
    logic [2*CFG_W-1:0] ifm_chunk_full;

    always_comb begin
        fil_vol     = {{2*CFG_W{1'b0}}, fil_y_q} * {{2*CFG_W{1'b0}}, fil_x_q}
                    * {{2*CFG_W{1'b0}}, div_q};
        ifm_row_vol = {{CFG_W{1'b0}}, ifm_x_q} * {{CFG_W{1'b0}}, div_q};
        fil_beats_w = ceil_div_bus(32'(fil_vol), LG_BUS);
        ifm_full_w  = ceil_div_bus(32'(ifm_row_vol), LG_BUS);
        cfg_err     = (ch_q == '0) || (div_q == '0) || (ifm_x_q == '0) || (ifm_y_q == '0)
                   || (fil_x_q == '0) || (fil_y_q == '0)
                   || (fil_beats_w > 32'(WR_DAT_CYC_NUM))
                   || (ifm_full_w > 32'(WR_DAT_CYC_NUM));
    end

    assign in_ready_o    = (state_q == FIL) || (state_q == IFM);
    assign accept        = in_valid_i && in_ready_o;
    assign mode          = (state_q == IFM) ? MODE_IFM : MODE_FIL;
    assign load_finish_o = (state_q == DONE);
    assign load_err_o    = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load_start_i) state_d = CALC;
            CALC:    state_d = cfg_err ? DONE : FIL;
            FIL:     if (accept && phase_last) state_d = IFM;
            IFM:     if (accept && phase_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            ch_q    <= '0;
            div_q   <= '0;
            ifm_x_q <= '0;
            ifm_y_q <= '0;
            fil_x_q <= '0;
            fil_y_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && load_start_i) begin
                err_q   <= 1'b0;
                ch_q    <= cfg_channel_num_i;
                div_q   <= cfg_div_channel_num_i;
                ifm_x_q <= cfg_ifm_x_i;
                ifm_y_q <= cfg_ifm_y_i;
                fil_x_q <= cfg_fil_x_i;
                fil_y_q <= cfg_fil_y_i;
            end else if ((state_q == CALC) && cfg_err) begin
                err_q <= 1'b1;
            end
        end
    end

    sram_chunk_counter #(
        .BUS_SIZE       (BUS_SIZE),
        .WR_DAT_CYC_NUM (WR_DAT_CYC_NUM),
        .CFG_W          (CFG_W)
    ) u_chunk_counter (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .init_i       (state_q == CALC),
        .adv_i        (accept),
        .mode_i       (mode),
        .ch_i         (ch_q),
        .div_i        (div_q),
        .ifm_x_i      (ifm_x_q),
        .ifm_y_i      (ifm_y_q),
        .fil_beats_i  (BEAT_W'(fil_beats_w)),
        .dat_o        (cnt_dat),
        .row_o        (cnt_row),
        .slice_o      (cnt_slice),
        .phase_last_o (phase_last)
    );

    assign ifm_chunk_full = {{CFG_W{1'b0}}, cnt_slice} * {{CFG_W{1'b0}}, ifm_y_q}
                          + {{CFG_W{1'b0}}, cnt_row};

    // Write ports: valid pulses for exactly one cycle per accepted beat; payload holds otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fil_sram_wr_valid_o        <= 1'b0;
            fil_sram_wr_sparsemap_o    <= '0;
            fil_sram_wr_nonzero_data_o <= '0;
            fil_sram_wr_dat_count_o    <= '0;
            fil_sram_wr_chunk_count_o  <= '0;
            ifm_sram_wr_valid_o        <= 1'b0;
            ifm_sram_wr_sparsemap_o    <= '0;
            ifm_sram_wr_nonzero_data_o <= '0;
            ifm_sram_wr_dat_count_o    <= '0;
            ifm_sram_wr_chunk_count_o  <= '0;
        end else begin
            fil_sram_wr_valid_o <= accept && (state_q == FIL);
            ifm_sram_wr_valid_o <= accept && (state_q == IFM);
            if (accept && (state_q == FIL)) begin
                fil_sram_wr_sparsemap_o    <= in_sparsemap_i;
                fil_sram_wr_nonzero_data_o <= in_nonzero_data_i;
                fil_sram_wr_dat_count_o    <= cnt_dat;
                fil_sram_wr_chunk_count_o  <= FIL_CW'(cnt_slice);
            end
            if (accept && (state_q == IFM)) begin
                ifm_sram_wr_sparsemap_o    <= in_sparsemap_i;
                ifm_sram_wr_nonzero_data_o <= in_nonzero_data_i;
                ifm_sram_wr_dat_count_o    <= cnt_dat;
                ifm_sram_wr_chunk_count_o  <= IFM_CW'(ifm_chunk_full);
            end
        end
    end

endmodule

// File: tb/tb_sram_load_scheduler.sv
// Directed bench for sram_load_scheduler: hand-sized chunk/beat tables per layer configuration,
// checked write-by-write with immediate assertions.
module tb_sram_load_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_start = 1'b0;
    logic [7:0]   cfg_ch = '0, cfg_div = '0, cfg_ix = '0, cfg_iy = '0, cfg_fx = '0, cfg_fy = '0;
    logic [31:0]  in_smap = '0;
    logic [255:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, load_finish, load_err;
    logic [31:0]  fil_smap, ifm_smap;
    logic [255:0] fil_data, ifm_data;
    logic         fil_v, ifm_v;
    logic [3:0]   fil_dat, fil_chunk, ifm_dat;
    logic [5:0]   ifm_chunk;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_port[$], exp_dat[$], exp_chunk[$];
    int last_fil_dat, last_fil_chunk, last_ifm_dat, last_ifm_chunk;

    always #5 clk = ~clk;

    sram_load_scheduler dut (
        .clk_i                      (clk),
        .rst_i                      (rst),
        .load_start_i               (load_start),
        .cfg_channel_num_i          (cfg_ch),
        .cfg_div_channel_num_i      (cfg_div),
        .cfg_ifm_x_i                (cfg_ix),
        .cfg_ifm_y_i                (cfg_iy),
        .cfg_fil_x_i                (cfg_fx),
        .cfg_fil_y_i                (cfg_fy),
        .in_sparsemap_i             (in_smap),
        .in_nonzero_data_i          (in_data),
        .in_valid_i                 (in_valid),
        .in_ready_o                 (in_ready),
        .load_finish_o              (load_finish),
        .load_err_o                 (load_err),
        .fil_sram_wr_sparsemap_o    (fil_smap),
        .fil_sram_wr_nonzero_data_o (fil_data),
        .fil_sram_wr_valid_o        (fil_v),
        .fil_sram_wr_dat_count_o    (fil_dat),
        .fil_sram_wr_chunk_count_o  (fil_chunk),
        .ifm_sram_wr_sparsemap_o    (ifm_smap),
        .ifm_sram_wr_nonzero_data_o (ifm_data),
        .ifm_sram_wr_valid_o        (ifm_v),
        .ifm_sram_wr_dat_count_o    (ifm_dat),
        .ifm_sram_wr_chunk_count_o  (ifm_chunk)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_smap(input int k);
        return 32'hC0DE_0000 | 32'(k);
    endfunction

    function automatic logic [255:0] mk_data(input int k);
        logic [31:0] w;
        w = 32'h1357_0000 + 32'(k) * 32'h0000_0101;
        return {8{w}};
    endfunction

    // port 0 = filter, 1 = IFM; chunks first..first+n-1, each with nbeats beats
    task automatic push_chunks(input int port, input int first, input int n, input int nbeats);
        for (int c = 0; c < n; c++)
            for (int b = 0; b < nbeats; b++) begin
                exp_port.push_back(port);
                exp_chunk.push_back(first + c);
                exp_dat.push_back(b);
            end
    endtask

    task automatic clear_exp();
        exp_port.delete();
        exp_dat.delete();
        exp_chunk.delete();
    endtask

    task automatic set_cfg(input logic [7:0] ch, div, ix, iy, fx, fy);
        cfg_ch = ch; cfg_div = div; cfg_ix = ix; cfg_iy = iy; cfg_fx = fx; cfg_fy = fy;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_fil_v"}, fil_v, 1'b0);
        chk({tag, "_ifm_v"}, ifm_v, 1'b0);
        chk({tag, "_fil_smap"}, fil_smap, 32'd0);
        chk({tag, "_fil_data"}, fil_data, 256'd0);
        chk({tag, "_fil_dat"}, fil_dat, 4'd0);
        chk({tag, "_fil_chunk"}, fil_chunk, 4'd0);
        chk({tag, "_ifm_smap"}, ifm_smap, 32'd0);
        chk({tag, "_ifm_data"}, ifm_data, 256'd0);
        chk({tag, "_ifm_dat"}, ifm_dat, 4'd0);
        chk({tag, "_ifm_chunk"}, ifm_chunk, 6'd0);
        chk({tag, "_finish"}, load_finish, 1'b0);
        chk({tag, "_err"}, load_err, 1'b0);
        chk({tag, "_ready"}, in_ready, 1'b0);
    endtask

    // gap=1 drives in_valid as 1,0,0,1,0,0...; inject_at>=0 pulses load_start when that beat is offered.
    task automatic run_load(input string name, input int gap, input int inject_at, input int exp_cycles);
        int  idx, cyc, total;
        bit  acc, done;
        total = exp_port.size();
        load_start = 1'b1;
        in_valid   = 1'b0;
        @(posedge clk); #1;
        load_start = 1'b0;
        chk({name, "_err_cleared"}, load_err, 1'b0);
        idx = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 600) begin
            in_valid   = (gap == 0) ? 1'b1 : ((cyc % 3) == 0);
            in_smap    = mk_smap(idx);
            in_data    = mk_data(idx);
            load_start = (inject_at >= 0) && (idx == inject_at);
            acc        = in_valid && in_ready;
            @(posedge clk); #1;
            load_start = 1'b0;
            cyc++;
            if (acc) begin
                if (idx < total) begin
                    chk({name, "_fil_v"}, fil_v, exp_port[idx] == 0);
                    chk({name, "_ifm_v"}, ifm_v, exp_port[idx] == 1);
                    if (exp_port[idx] == 0) begin
                        chk({name, "_fil_smap"}, fil_smap, mk_smap(idx));
                        chk({name, "_fil_data"}, fil_data, mk_data(idx));
                        chk({name, "_fil_dat"}, fil_dat, exp_dat[idx]);
                        chk({name, "_fil_chunk"}, fil_chunk, exp_chunk[idx]);
                        last_fil_dat = exp_dat[idx]; last_fil_chunk = exp_chunk[idx];
                    end else begin
                        chk({name, "_ifm_smap"}, ifm_smap, mk_smap(idx));
                        chk({name, "_ifm_data"}, ifm_data, mk_data(idx));
                        chk({name, "_ifm_dat"}, ifm_dat, exp_dat[idx]);
                        chk({name, "_ifm_chunk"}, ifm_chunk, exp_chunk[idx]);
                        last_ifm_dat = exp_dat[idx]; last_ifm_chunk = exp_chunk[idx];
                    end
                    $display("%s write %0d: port=%0d chunk=%0d dat=%0d", name, idx,
                             exp_port[idx], exp_chunk[idx], exp_dat[idx]);
                end else begin
                    chk({name, "_write_count"}, idx + 1, total);
                end
                idx++;
            end else begin
                chk({name, "_gap_fil_v"}, fil_v, 1'b0);
                chk({name, "_gap_ifm_v"}, ifm_v, 1'b0);
                chk({name, "_hold_fil_dat"}, fil_dat, last_fil_dat);
                chk({name, "_hold_fil_chunk"}, fil_chunk, last_fil_chunk);
                chk({name, "_hold_ifm_dat"}, ifm_dat, last_ifm_dat);
                chk({name, "_hold_ifm_chunk"}, ifm_chunk, last_ifm_chunk);
            end
            if (load_finish) done = 1'b1;
        end
        chk({name, "_finish_seen"}, done, 1'b1);
        chk({name, "_writes_at_finish"}, idx, total);
        if (exp_cycles > 0) chk({name, "_cycles"}, cyc, exp_cycles);
        chk({name, "_no_err"}, load_err, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk({name, "_finish_pulse"}, load_finish, 1'b0);
        chk({name, "_idle_ready"}, in_ready, 1'b0);
        chk({name, "_idle_fil_v"}, fil_v, 1'b0);
        chk({name, "_idle_ifm_v"}, ifm_v, 1'b0);
        in_valid = 1'b0;
        $display("%s: %0d writes in %0d cycles", name, idx, cyc);
    endtask

    task automatic run_err(input string name);
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        chk({name, "_calc_finish"}, load_finish, 1'b0);
        chk({name, "_calc_ready"}, in_ready, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk({name, "_finish"}, load_finish, 1'b1);
        chk({name, "_err"}, load_err, 1'b1);
        chk({name, "_fil_v"}, fil_v, 1'b0);
        chk({name, "_ifm_v"}, ifm_v, 1'b0);
        @(posedge clk); #1;
        chk({name, "_finish_pulse"}, load_finish, 1'b0);
        chk({name, "_err_sticky"}, load_err, 1'b1);
        chk({name, "_ready"}, in_ready, 1'b0);
        chk({name, "_fil_v2"}, fil_v, 1'b0);
        in_valid = 1'b0;
        $display("%s: error response checked", name);
    endtask

    task automatic exp_base();
        // ch=64 div=32 fil 3x3 ifm 4x2: fil 2x9 beats, ifm chunks 0..3 x 4 beats
        clear_exp();
        push_chunks(0, 0, 2, 9);
        push_chunks(1, 0, 4, 4);
    endtask

    initial begin
        last_fil_dat = 0; last_fil_chunk = 0; last_ifm_dat = 0; last_ifm_chunk = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        $display("reset: outputs checked");

        set_cfg(8'd64, 8'd32, 8'd4, 8'd2, 8'd3, 8'd3);
        exp_base();
        run_load("base", 0, -1, 35);

        // ch=40: slice 1 has cz=8 -> ifm chunks 2,3 get 1 beat; fil stays 9 beats
        set_cfg(8'd40, 8'd32, 8'd4, 8'd2, 8'd3, 8'd3);
        clear_exp();
        push_chunks(0, 0, 2, 9);
        push_chunks(1, 0, 2, 4);
        push_chunks(1, 2, 2, 1);
        run_load("short_slice", 0, -1, 29);

        set_cfg(8'd64, 8'd32, 8'd4, 8'd2, 8'd3, 8'd3);
        exp_base();
        run_load("gaps", 1, -1, -1);

        set_cfg(8'd64, 8'd0, 8'd4, 8'd2, 8'd3, 8'd3);
        run_err("err_div0");
        set_cfg(8'd64, 8'd32, 8'd4, 8'd2, 8'd0, 8'd3);
        run_err("err_filx0");
        set_cfg(8'd64, 8'd32, 8'd4, 8'd2, 8'd5, 8'd5);
        run_err("err_fil25");

        set_cfg(8'd64, 8'd32, 8'd4, 8'd2, 8'd3, 8'd3);
        exp_base();
        run_load("after_err", 0, -1, 35);

        // Reset while filter beat 5 is being offered
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_smap = mk_smap(k);
            in_data = mk_data(k);
            @(posedge clk); #1;
        end
        chk("pre_reset_fil_dat", fil_dat, 4'd4);
        rst = 1'b1;
        in_smap = mk_smap(5);
        in_data = mk_data(5);
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("midreset");
        @(posedge clk); #1;
        chk("midreset_idle_fil_v", fil_v, 1'b0);
        chk("midreset_idle_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        last_fil_dat = 0; last_fil_chunk = 0; last_ifm_dat = 0; last_ifm_chunk = 0;
        $display("midreset: outputs checked");

        exp_base();
        run_load("replay", 0, -1, 35);

        exp_base();
        run_load("start_in_ifm", 0, 20, 35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
